// File: rtl/reservation_station_pkg.sv
// reservation_station_pkg: shared widths and opcode constants for the RS slice
package reservation_station_pkg;
  localparam int ROB_SIZE_WIDTH = 4;
  localparam int RS_SIZE = 8;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
endpackage

// File: rtl/rs_select.sv
// rs_select: lowest-index set-bit finder over a request vector
module rs_select #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? i[$clog2(N)-1:0] : idx;
  end
  assign found = |req;
endmodule

// File: rtl/reservation_station.sv
// reservation_station: holds ALU/branch ops until both operands are ready, issues one per cycle
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE = reservation_station_pkg::RS_SIZE,
  parameter int ROB_W = reservation_station_pkg::ROB_SIZE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             dis_valid,
  input  logic [ROB_W-1:0] dis_rob_id,
  input  logic [2:0]       dis_op,
  input  logic [6:0]       dis_type,
  input  logic             dis_op_other,
  input  logic             dis_qj_busy,
  input  logic             dis_qk_busy,
  input  logic [ROB_W-1:0] dis_qj,
  input  logic [ROB_W-1:0] dis_qk,
  input  logic [31:0]      dis_vj,
  input  logic [31:0]      dis_vk,
  output logic             rs_full,
  input  logic             cdb_alu_valid,
  input  logic [ROB_W-1:0] cdb_alu_rob_id,
  input  logic [31:0]      cdb_alu_value,
  input  logic             cdb_lsb_valid,
  input  logic [ROB_W-1:0] cdb_lsb_rob_id,
  input  logic [31:0]      cdb_lsb_value,
  output logic             alu_valid,
  output logic [ROB_W-1:0] alu_rob_id,
  output logic [2:0]       alu_op,
  output logic [6:0]       alu_type,
  output logic             alu_op_other,
  output logic [31:0]      alu_v1,
  output logic [31:0]      alu_v2
);
  localparam int SW = $clog2(RS_SIZE);
  logic [RS_SIZE-1:0] busy_d, busy_q, qjb_d, qjb_q, qkb_d, qkb_q, oth_d, oth_q;
  logic [ROB_W-1:0] rob_d [RS_SIZE], rob_q [RS_SIZE], qj_d [RS_SIZE], qj_q [RS_SIZE], qk_d [RS_SIZE], qk_q [RS_SIZE];
  logic [2:0] op_d [RS_SIZE], op_q [RS_SIZE];
  logic [6:0] type_d [RS_SIZE], type_q [RS_SIZE];
  logic [31:0] vj_d [RS_SIZE], vj_q [RS_SIZE], vk_d [RS_SIZE], vk_q [RS_SIZE];
  logic alu_valid_d, alu_valid_q, alu_oth_d, alu_oth_q;
  logic [ROB_W-1:0] alu_rob_d, alu_rob_q;
  logic [2:0] alu_op_d, alu_op_q;
  logic [6:0] alu_type_d, alu_type_q;
  logic [31:0] alu_v1_d, alu_v1_q, alu_v2_d, alu_v2_q;
  logic [SW-1:0] free_idx, sel_idx;
  logic free_found, sel_found;
  logic [32:0] fj, fk;
  rs_select #(.N(RS_SIZE)) u_free (.req(~busy_q), .idx(free_idx), .found(free_found));
  rs_select #(.N(RS_SIZE)) u_sel (.req(busy_q & ~qjb_q & ~qkb_q), .idx(sel_idx), .found(sel_found));
  // returns {still_pending, value}; the ALU broadcast wins a tag collision
  function automatic logic [32:0] snoop(input logic pend, input logic [ROB_W-1:0] tag, input logic [31:0] val);
    snoop = {pend, val};
    if (pend && cdb_lsb_valid && cdb_lsb_rob_id == tag) snoop = {1'b0, cdb_lsb_value};
    if (pend && cdb_alu_valid && cdb_alu_rob_id == tag) snoop = {1'b0, cdb_alu_value};
  endfunction
  always_comb begin
    busy_d = busy_q;
    qjb_d = qjb_q;
    qkb_d = qkb_q;
    oth_d = oth_q;
    rob_d = rob_q;
    qj_d = qj_q;
    qk_d = qk_q;
    op_d = op_q;
    type_d = type_q;
    vj_d = vj_q;
    vk_d = vk_q;
    alu_valid_d = alu_valid_q;
    alu_rob_d = alu_rob_q;
    alu_op_d = alu_op_q;
    alu_type_d = alu_type_q;
    alu_oth_d = alu_oth_q;
    alu_v1_d = alu_v1_q;
    alu_v2_d = alu_v2_q;
    fj = snoop(dis_qj_busy, dis_qj, dis_vj);
    fk = snoop(dis_qk_busy, dis_qk, dis_vk);
    if (rdy) begin
      alu_valid_d = sel_found;
      if (sel_found) begin
        alu_rob_d = rob_q[sel_idx];
        alu_op_d = op_q[sel_idx];
        alu_type_d = type_q[sel_idx];
        alu_oth_d = oth_q[sel_idx];
        alu_v1_d = vj_q[sel_idx];
        alu_v2_d = vk_q[sel_idx];
        busy_d[sel_idx] = 1'b0;
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i]) begin
          {qjb_d[i], vj_d[i]} = snoop(qjb_q[i], qj_q[i], vj_q[i]);
          {qkb_d[i], vk_d[i]} = snoop(qkb_q[i], qk_q[i], vk_q[i]);
        end
      end
      // the free slot is never the selected one, so issue and dispatch cannot collide
      if (dis_valid && free_found) begin
        busy_d[free_idx] = 1'b1;
        rob_d[free_idx] = dis_rob_id;
        op_d[free_idx] = dis_op;
        type_d[free_idx] = dis_type;
        oth_d[free_idx] = dis_op_other;
        qj_d[free_idx] = dis_qj;
        qk_d[free_idx] = dis_qk;
        {qjb_d[free_idx], vj_d[free_idx]} = fj;
        {qkb_d[free_idx], vk_d[free_idx]} = fk;
      end
      if (clear) begin
        busy_d = '0;
        alu_valid_d = 1'b0;
      end
    end
    if (rst) begin
      busy_d = '0;
      qjb_d = '0;
      qkb_d = '0;
      oth_d = '0;
      rob_d = '{default: '0};
      qj_d = '{default: '0};
      qk_d = '{default: '0};
      op_d = '{default: '0};
      type_d = '{default: '0};
      vj_d = '{default: '0};
      vk_d = '{default: '0};
      alu_valid_d = 1'b0;
      alu_rob_d = '0;
      alu_op_d = '0;
      alu_type_d = '0;
      alu_oth_d = 1'b0;
      alu_v1_d = '0;
      alu_v2_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    busy_q <= busy_d;
    qjb_q <= qjb_d;
    qkb_q <= qkb_d;
    oth_q <= oth_d;
    rob_q <= rob_d;
    qj_q <= qj_d;
    qk_q <= qk_d;
    op_q <= op_d;
    type_q <= type_d;
    vj_q <= vj_d;
    vk_q <= vk_d;
    alu_valid_q <= alu_valid_d;
    alu_rob_q <= alu_rob_d;
    alu_op_q <= alu_op_d;
    alu_type_q <= alu_type_d;
    alu_oth_q <= alu_oth_d;
    alu_v1_q <= alu_v1_d;
    alu_v2_q <= alu_v2_d;
  end
  assign rs_full = &busy_q;
  assign alu_valid = alu_valid_q;
  assign alu_rob_id = alu_rob_q;
  assign alu_op = alu_op_q;
  assign alu_type = alu_type_q;
  assign alu_op_other = alu_oth_q;
  assign alu_v1 = alu_v1_q;
  assign alu_v2 = alu_v2_q;
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed test-plan scenarios plus random traffic against a slot-array model
module tb_reservation_station;
  import reservation_station_pkg::*;
  localparam int N = RS_SIZE;
  localparam int W = ROB_SIZE_WIDTH;
  logic clk = 1'b0;
  logic rst, rdy, clear, dis_valid, dis_op_other, dis_qj_busy, dis_qk_busy;
  logic [W-1:0] dis_rob_id, dis_qj, dis_qk, cdb_alu_rob_id, cdb_lsb_rob_id;
  logic [2:0] dis_op;
  logic [6:0] dis_type;
  logic [31:0] dis_vj, dis_vk, cdb_alu_value, cdb_lsb_value;
  logic cdb_alu_valid, cdb_lsb_valid, rs_full;
  logic alu_valid, alu_op_other;
  logic [W-1:0] alu_rob_id;
  logic [2:0] alu_op;
  logic [6:0] alu_type;
  logic [31:0] alu_v1, alu_v2;
  always #5 clk = ~clk;
  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .dis_valid(dis_valid), .dis_rob_id(dis_rob_id), .dis_op(dis_op), .dis_type(dis_type),
    .dis_op_other(dis_op_other), .dis_qj_busy(dis_qj_busy), .dis_qk_busy(dis_qk_busy),
    .dis_qj(dis_qj), .dis_qk(dis_qk), .dis_vj(dis_vj), .dis_vk(dis_vk), .rs_full(rs_full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob_id(cdb_alu_rob_id), .cdb_alu_value(cdb_alu_value),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob_id(cdb_lsb_rob_id), .cdb_lsb_value(cdb_lsb_value),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_op(alu_op), .alu_type(alu_type),
    .alu_op_other(alu_op_other), .alu_v1(alu_v1), .alu_v2(alu_v2)
  );
  typedef struct {
    logic busy;
    logic [W-1:0] rob, qj, qk;
    logic [2:0] op;
    logic [6:0] typ;
    logic oth, jb, kb;
    logic [31:0] vj, vk;
  } ent_t;
  ent_t m [N];
  logic e_valid, e_oth;
  logic [W-1:0] e_rob;
  logic [2:0] e_op;
  logic [6:0] e_type;
  logic [31:0] e_v1, e_v2;
  int checks = 0;
  int failures = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [32:0] cap(input logic pend, input logic [W-1:0] t, input logic [31:0] v);
    if (pend && cdb_alu_valid && cdb_alu_rob_id == t) return {1'b0, cdb_alu_value};
    if (pend && cdb_lsb_valid && cdb_lsb_rob_id == t) return {1'b0, cdb_lsb_value};
    return {pend, v};
  endfunction
  task automatic model_step();
    int s, f;
    bit full;
    logic [32:0] r;
    if (rst) begin
      foreach (m[i]) m[i] = '{default: '0};
      {e_valid, e_oth, e_rob, e_op, e_type, e_v1, e_v2} = '0;
      return;
    end
    if (!rdy) return;
    full = 1;
    s = -1;
    f = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (!m[i].busy) begin full = 0; f = i; end
      if (m[i].busy && !m[i].jb && !m[i].kb) s = i;
    end
    e_valid = (s >= 0);
    if (s >= 0) begin
      e_rob = m[s].rob; e_op = m[s].op; e_type = m[s].typ;
      e_oth = m[s].oth; e_v1 = m[s].vj; e_v2 = m[s].vk;
    end
    for (int i = 0; i < N; i++) if (m[i].busy) begin
      r = cap(m[i].jb, m[i].qj, m[i].vj); m[i].jb = r[32]; m[i].vj = r[31:0];
      r = cap(m[i].kb, m[i].qk, m[i].vk); m[i].kb = r[32]; m[i].vk = r[31:0];
    end
    if (dis_valid && !full) begin
      m[f].busy = 1; m[f].rob = dis_rob_id; m[f].op = dis_op; m[f].typ = dis_type;
      m[f].oth = dis_op_other; m[f].qj = dis_qj; m[f].qk = dis_qk;
      r = cap(dis_qj_busy, dis_qj, dis_vj); m[f].jb = r[32]; m[f].vj = r[31:0];
      r = cap(dis_qk_busy, dis_qk, dis_vk); m[f].kb = r[32]; m[f].vk = r[31:0];
    end
    if (s >= 0) m[s].busy = 0;
    if (clear) begin
      foreach (m[i]) m[i].busy = 0;
      e_valid = 0;
    end
  endtask
  task automatic step();
    bit full;
    @(posedge clk);
    model_step();
    #1;
    full = 1;
    foreach (m[i]) if (!m[i].busy) full = 0;
    chk("alu_valid", alu_valid, e_valid);
    chk("alu_rob_id", alu_rob_id, e_rob);
    chk("alu_op", alu_op, e_op);
    chk("alu_type", alu_type, e_type);
    chk("alu_op_other", alu_op_other, e_oth);
    chk("alu_v1", alu_v1, e_v1);
    chk("alu_v2", alu_v2, e_v2);
    chk("rs_full", rs_full, full);
  endtask
  task automatic idle();
    rst = 0; rdy = 1; clear = 0; dis_valid = 0; cdb_alu_valid = 0; cdb_lsb_valid = 0;
  endtask
  task automatic dis(input int rob, input logic jb, input int qj, input int vj,
                     input logic kb, input int qk, input int vk);
    dis_valid = 1; dis_rob_id = W'(rob); dis_op = 3'd0; dis_type = OP_REG; dis_op_other = 0;
    dis_qj_busy = jb; dis_qj = W'(qj); dis_vj = vj;
    dis_qk_busy = kb; dis_qk = W'(qk); dis_vk = vk;
  endtask
  initial begin
    idle();
    {dis_rob_id, dis_op, dis_type, dis_op_other, dis_qj_busy, dis_qk_busy, dis_qj, dis_qk, dis_vj, dis_vk} = '0;
    {cdb_alu_rob_id, cdb_lsb_rob_id, cdb_alu_value, cdb_lsb_value} = '0;
    rst = 1;
    step();
    chk("rst_valid", alu_valid, 0);
    chk("rst_full", rs_full, 0);
    idle();
    // ready add: issues on the second edge after dispatch
    dis(3, 0, 0, 5, 0, 0, 7);
    step();
    chk("t1_early", alu_valid, 0);
    idle();
    step();
    chk("t1_valid", alu_valid, 1);
    chk("t1_rob", alu_rob_id, 3);
    chk("t1_v1", alu_v1, 5);
    chk("t1_v2", alu_v2, 7);
    step();
    chk("t1_full", rs_full, 0);
    chk("t1_once", alu_valid, 0);
    // wake-up from the ALU broadcast
    dis(2, 1, 1, 0, 0, 0, 9);
    step();
    idle();
    cdb_alu_valid = 1; cdb_alu_rob_id = 4'd1; cdb_alu_value = 32'h10;
    step();
    chk("t2_wait", alu_valid, 0);
    idle();
    step();
    chk("t2_valid", alu_valid, 1);
    chk("t2_rob", alu_rob_id, 2);
    chk("t2_v1", alu_v1, 32'h10);
    // dispatch-time forwarding from the load broadcast
    dis(5, 0, 0, 1, 1, 4, 0);
    cdb_lsb_valid = 1; cdb_lsb_rob_id = 4'd4; cdb_lsb_value = 32'hFFFF_FFFF;
    step();
    idle();
    step();
    chk("t3_valid", alu_valid, 1);
    chk("t3_rob", alu_rob_id, 5);
    chk("t3_v2", alu_v2, 32'hFFFF_FFFF);
    // fill, reject a ninth, then drain in index order
    for (int i = 0; i < N; i++) begin
      dis(i, 1, 7, 0, 0, 0, i);
      step();
    end
    chk("t4_full", rs_full, 1);
    dis(9, 0, 0, 1, 0, 0, 1);
    step();
    chk("t4_drop_full", rs_full, 1);
    chk("t4_drop_noissue", alu_valid, 0);
    idle();
    cdb_alu_valid = 1; cdb_alu_rob_id = 4'd7; cdb_alu_value = 32'h77;
    step();
    idle();
    for (int i = 0; i < N; i++) begin
      step();
      chk("t4_order_valid", alu_valid, 1);
      chk("t4_order_rob", alu_rob_id, i);
      chk("t4_order_v1", alu_v1, 32'h77);
    end
    step();
    chk("t4_drained", alu_valid, 0);
    chk("t4_empty", rs_full, 0);
    // flush with a dispatch in the same cycle
    for (int i = 0; i < 3; i++) begin
      dis(10 + i, 1, 9, 0, 0, 0, 0);
      step();
    end
    dis(12, 0, 0, 3, 0, 0, 4);
    clear = 1;
    step();
    chk("t5_full", rs_full, 0);
    chk("t5_valid", alu_valid, 0);
    idle();
    cdb_alu_valid = 1; cdb_alu_rob_id = 4'd9;
    step();
    idle();
    step();
    chk("t5_gone", alu_valid, 0);
    step();
    chk("t5_gone2", alu_valid, 0);
    // stall on rdy
    dis(6, 0, 0, 11, 0, 0, 12);
    step();
    idle();
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_stall", alu_valid, 0);
    end
    rdy = 1;
    step();
    chk("t6_valid", alu_valid, 1);
    chk("t6_rob", alu_rob_id, 6);
    chk("t6_v1", alu_v1, 11);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 49) == 0);
      dis_valid = $urandom_range(0, 1);
      dis_rob_id = W'($urandom);
      dis_op = 3'($urandom);
      case ($urandom_range(0, 2))
        0: dis_type = OP_IMM;
        1: dis_type = OP_REG;
        default: dis_type = OP_BRANCH;
      endcase
      dis_op_other = $urandom_range(0, 1);
      dis_qj_busy = $urandom_range(0, 1);
      dis_qk_busy = $urandom_range(0, 1);
      dis_qj = W'($urandom_range(0, 7));
      dis_qk = W'($urandom_range(0, 7));
      dis_vj = $urandom;
      dis_vk = $urandom;
      cdb_alu_valid = ($urandom_range(0, 9) < 4);
      cdb_lsb_valid = ($urandom_range(0, 9) < 4);
      cdb_alu_rob_id = W'($urandom_range(0, 7));
      cdb_lsb_rob_id = W'($urandom_range(0, 7));
      cdb_alu_value = $urandom;
      cdb_lsb_value = $urandom;
      if (cdb_alu_valid && cdb_lsb_valid && cdb_alu_rob_id == cdb_lsb_rob_id) cdb_lsb_valid = 0;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
